sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-master arbiter and timing sequencer for the board's asynchronous 256Kx16 SRAM pair, which forms one 32-bit word-addressed memory.
- Typical masters: CPU instruction fetch (m0) and CPU data/DMA (m1).
- Grants one master at a time, round-robin, and generates CE_/OE_/WE_ timing with programmable wait states.
- Split data-in/data-out/output-enable; the top level builds the tristate onto the shared IO bus.

Parameters:
- AWIDTH, 18, SRAM word-address width; the low AWIDTH bits of the master address are used.
- DWIDTH, 32, data width (two 16-bit parts side by side).
- RD_WAIT, 1, extra cycles of OE_ low before read data is sampled (0..15).
- WR_WAIT, 1, extra cycles of WE_ low beyond the minimum one (0..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_we  in  1  master 0: 1=write, 0=read
- m0_addr  in  30  master 0 word address
- m0_wdata  in  DWIDTH  master 0 write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DWIDTH  read data; valid when m0_ack=1
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0
- sram_addr  out  AWIDTH  SRAM address
- sram_dq_o  out  DWIDTH  write data to pads
- sram_dq_oe  out  1  pad drive enable
- sram_dq_i  in  DWIDTH  read data from pads
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low

Behaviour:
- All outputs are registered.
- Reset values: ce_n=oe_n=we_n=1, dq_oe=0, sram_addr=0, dq_o=0, acks=0, rdata=0, state=IDLE, rr_last=1 (m0 wins first).
- Reset asserted mid-operation: outputs go to reset values immediately and no ack is issued. A truncated SRAM write is accepted behaviour.
- FSM states: IDLE, RD, WS, WP, WH, DONE.
- IDLE:
  - If any req is high, grant using round-robin: if both are high, grant the master other than rr_last; otherwise grant the sole requester.
  - At the grant edge, latch we/addr/wdata and master id, and update rr_last.
  - Go to RD or WS.
- RD:
  - ce_n=0, oe_n=0, dq_oe=0, addr driven.
  - Stays RD_WAIT+1 cycles (4-bit down-counter).
  - On the final edge, capture sram_dq_i into the granted master's rdata, then go to DONE.
- WS: ce_n=0, we_n=1, dq_oe=1, addr and data driven. Lasts 1 cycle, then WP.
- WP: we_n=0, addr and data held. Lasts WR_WAIT+1 cycles, then WH.
- WH: we_n=1, ce_n=0, data still driven for hold time. Lasts 1 cycle, then DONE.
- DONE:
  - Granted master's ack=1 for exactly this cycle.
  - ce_n=oe_n=we_n=1, dq_oe=0; the idle cycle doubles as bus turnaround.
  - Go to IDLE.
- Requests are not sampled in DONE. A req still high in the following IDLE is treated as a new request.
- Read latency from IDLE-with-req: ack in cycle RD_WAIT+2 after the grant cycle (cycle 3 at default).
- Write latency: ack in cycle WR_WAIT+4 (cycle 5 at default).
- oe_n and we_n are never low in the same cycle; dq_oe is never 1 while oe_n=0.
- m*_rdata holds its value until the next read for that master.
- Req dropped mid-access is illegal: the access completes and ack still pulses.
- Address bits above AWIDTH are ignored (the address aliases).
- Continuous requests from both masters: strict alternation m0,m1,m0,...; no starvation.

Decomposition:
- Package sram_arb_pkg: state enum, master-id type, default RD_WAIT/WR_WAIT constants, width localparams.
- One sub-module, sram_rr_arb: 2-way round-robin grant logic with rr_last register and grant-enable input.
- FSM and output registers stay in sram_arbiter.

Test Plan:
- Single read: SRAM word 0x00010 preloaded 0xDEADBEEF; m0 reads 0x10 → oe_n low for 2 cycles, m0_ack in cycle 3, m0_rdata=0xDEADBEEF, m1_ack stays 0.
- Single write then read: m1 writes 0x12345678 to 0x3FFFF → we_n low for exactly 2 cycles, with dq_oe=1 from WS through WH. A later m0 read of 0x3FFFF returns 0x12345678.
- Contention: m0 and m1 both req from reset, m0 reading 0x1 and m1 writing 0x2 → grant order m0, m1, m0, m1 while held; each ack is one cycle; never both acks in one cycle.
- Parameter sweep: RD_WAIT=0 and 3, WR_WAIT=0 and 3 → ack cycles 2/5 (reads) and 4/7 (writes); model SRAM data matches.
- Reset mid-write: assert rst during WP → ce_n=we_n=1 and dq_oe=0 immediately; no ack; after release, m0 is granted first.
- Aliasing: m0 writes 0xA5A5A5A5 to 0x0C0001 → SRAM word 0x00001 holds 0xA5A5A5A5.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master async SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned MADDR_W     = 30;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned AWIDTH_DEF  = 18;
    localparam int unsigned DWIDTH_DEF  = 32;
    localparam int unsigned RD_WAIT_DEF = 1;
    localparam int unsigned WR_WAIT_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WS,
        ST_WP,
        ST_WH,
        ST_DONE
    } state_t;

    // 0 = master 0, 1 = master 1
    typedef logic mid_t;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way round-robin grant; rr_last only moves when a grant is taken.
module sram_rr_arb
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic       o_gnt_c,
    output logic       o_gnt_id_c
);

    logic r_rr_last;

    // Both requesting: the master that did not win last time goes next
    always_comb begin
        o_gnt_c    = |i_req;
        o_gnt_id_c = i_req[1];
        if (i_req == 2'b11) begin
            o_gnt_id_c = ~r_rr_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= 1'b1;
        end else if (i_en && o_gnt_c) begin
            r_rr_last <= o_gnt_id_c;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter and CE_/OE_/WE_ sequencer for a 32-bit async SRAM pair.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned AWIDTH  = AWIDTH_DEF,
    parameter int unsigned DWIDTH  = DWIDTH_DEF,
    parameter int unsigned RD_WAIT = RD_WAIT_DEF,
    parameter int unsigned WR_WAIT = WR_WAIT_DEF
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               m0_req,
    input  logic               m0_we,
    input  logic [MADDR_W-1:0] m0_addr,
    input  logic [DWIDTH-1:0]  m0_wdata,
    output logic               m0_ack,
    output logic [DWIDTH-1:0]  m0_rdata,
    input  logic               m1_req,
    input  logic               m1_we,
    input  logic [MADDR_W-1:0] m1_addr,
    input  logic [DWIDTH-1:0]  m1_wdata,
    output logic               m1_ack,
    output logic [DWIDTH-1:0]  m1_rdata,
    output logic [AWIDTH-1:0]  sram_addr,
    output logic [DWIDTH-1:0]  sram_dq_o,
    output logic               sram_dq_oe,
    input  logic [DWIDTH-1:0]  sram_dq_i,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_id;
    logic               w_gnt;
    logic               w_gnt_id;
    logic               w_sel_we;
    logic [MADDR_W-1:0] w_sel_addr;
    logic [DWIDTH-1:0]  w_sel_wdata;
    logic               w_unused_addr;

    sram_rr_arb u_rr (
        .clk        (clk),
        .rst        (rst),
        .i_req      ({m1_req, m0_req}),
        .i_en       (r_state == ST_IDLE),
        .o_gnt_c    (w_gnt),
        .o_gnt_id_c (w_gnt_id)
    );

    assign w_sel_we    = w_gnt_id ? m1_we    : m0_we;
    assign w_sel_addr  = w_gnt_id ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_gnt_id ? m1_wdata : m0_wdata;

    // Upper address bits alias onto the SRAM
    assign w_unused_addr = ^{m0_addr[MADDR_W-1:AWIDTH], m1_addr[MADDR_W-1:AWIDTH]};

    // Outputs are set on the edge entering each state, so they are valid for that whole state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_id       <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt) begin
                        r_id      <= w_gnt_id;
                        sram_addr <= w_sel_addr[AWIDTH-1:0];
                        sram_ce_n <= 1'b0;
                        if (w_sel_we) begin
                            sram_dq_o  <= w_sel_wdata;
                            sram_dq_oe <= 1'b1;
                            r_state    <= ST_WS;
                        end else begin
                            sram_oe_n <= 1'b0;
                            r_cnt     <= CNT_W'(RD_WAIT);
                            r_state   <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (r_cnt == '0) begin
                        if (r_id) begin
                            m1_rdata <= sram_dq_i;
                            m1_ack   <= 1'b1;
                        end else begin
                            m0_rdata <= sram_dq_i;
                            m0_ack   <= 1'b1;
                        end
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_WS: begin
                    sram_we_n <= 1'b0;
                    r_cnt     <= CNT_W'(WR_WAIT);
                    r_state   <= ST_WP;
                end
                ST_WP: begin
                    if (r_cnt == '0) begin
                        sram_we_n <= 1'b1;
                        r_state   <= ST_WH;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_WH: begin
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    if (r_id) begin
                        m1_ack <= 1'b1;
                    end else begin
                        m0_ack <= 1'b1;
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: three arbiter instances (default, RD0/WR3, RD3/WR0) each on a behavioural SRAM.
module tb_sram_arbiter;

    localparam int NI = 3;
    localparam int RDW [NI] = '{1, 0, 3};
    localparam int WRW [NI] = '{1, 3, 0};

    logic          clk;
    logic          rst;
    logic [NI-1:0] m0_req, m0_we, m0_ack, m1_req, m1_we, m1_ack;
    logic [29:0]   m0_addr [NI];
    logic [29:0]   m1_addr [NI];
    logic [31:0]   m0_wdata [NI];
    logic [31:0]   m1_wdata [NI];
    logic [31:0]   m0_rdata [NI];
    logic [31:0]   m1_rdata [NI];
    logic [17:0]   sram_addr [NI];
    logic [31:0]   dq_o [NI];
    logic [31:0]   dq_i [NI];
    logic [NI-1:0] dq_oe, ce_n, oe_n, we_n;
    logic [31:0]   mem [NI][0:262143];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        sram_arbiter #(
            .AWIDTH  (18),
            .DWIDTH  (32),
            .RD_WAIT (RDW[g]),
            .WR_WAIT (WRW[g])
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .m0_req     (m0_req[g]),
            .m0_we      (m0_we[g]),
            .m0_addr    (m0_addr[g]),
            .m0_wdata   (m0_wdata[g]),
            .m0_ack     (m0_ack[g]),
            .m0_rdata   (m0_rdata[g]),
            .m1_req     (m1_req[g]),
            .m1_we      (m1_we[g]),
            .m1_addr    (m1_addr[g]),
            .m1_wdata   (m1_wdata[g]),
            .m1_ack     (m1_ack[g]),
            .m1_rdata   (m1_rdata[g]),
            .sram_addr  (sram_addr[g]),
            .sram_dq_o  (dq_o[g]),
            .sram_dq_oe (dq_oe[g]),
            .sram_dq_i  (dq_i[g]),
            .sram_ce_n  (ce_n[g]),
            .sram_oe_n  (oe_n[g]),
            .sram_we_n  (we_n[g])
        );
        assign dq_i[g] = (!ce_n[g] && !oe_n[g]) ? mem[g][sram_addr[g]] : 32'h0;
    end

    // SRAM model: a word is written while CE_ and WE_ are both low
    always @(posedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!ce_n[g] && !we_n[g]) mem[g][sram_addr[g]] = dq_o[g];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access on instance k by master m; checks latency, strobe widths and strobe exclusivity
    task automatic access(input int k, input bit m, input bit we, input logic [29:0] a,
                          input logic [31:0] wd, input int exp_lat, input logic [31:0] exp_rd);
        int lat = 0, oe_cnt = 0, we_cnt = 0, drv_cnt = 0;
        bit viol = 0, other = 0, mine;
        @(negedge clk);
        if (!m) begin
            m0_we[k] = we; m0_addr[k] = a; m0_wdata[k] = wd; m0_req[k] = 1'b1;
        end else begin
            m1_we[k] = we; m1_addr[k] = a; m1_wdata[k] = wd; m1_req[k] = 1'b1;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!oe_n[k]) oe_cnt++;
            if (!we_n[k]) we_cnt++;
            if (dq_oe[k]) drv_cnt++;
            if (!oe_n[k] && (!we_n[k] || dq_oe[k])) viol = 1;
            mine = m ? m1_ack[k] : m0_ack[k];
            if (m ? m0_ack[k] : m1_ack[k]) other = 1;
            if (mine) begin
                lat = c;
                break;
            end
        end
        m0_req[k] = 1'b0;
        m1_req[k] = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("strobe_overlap", 32'(viol), 32'd0);
        chk("other_ack", 32'(other), 32'd0);
        if (we) begin
            chk("we_low_cycles", 32'(we_cnt), 32'(WRW[k] + 1));
            chk("dq_oe_cycles", 32'(drv_cnt), 32'(WRW[k] + 3));
            chk("wr_oe_cycles", 32'(oe_cnt), 32'd0);
        end else begin
            chk("oe_low_cycles", 32'(oe_cnt), 32'(RDW[k] + 1));
            chk("rd_dq_oe", 32'(drv_cnt), 32'd0);
            chk("rdata", m ? m1_rdata[k] : m0_rdata[k], exp_rd);
        end
    endtask

    initial begin
        int n;
        int ord [4];
        bit both, seen, ackseen;

        rst = 1'b1;
        m0_req = '0; m0_we = '0; m1_req = '0; m1_we = '0;
        for (int i = 0; i < NI; i++) begin
            m0_addr[i] = '0; m1_addr[i] = '0; m0_wdata[i] = '0; m1_wdata[i] = '0;
        end
        mem[0][18'h00010] = 32'hDEADBEEF;
        mem[0][18'h00001] = 32'h01010101;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ce_n", 32'(ce_n[0]), 32'd1);
        chk("rst_oe_n", 32'(oe_n[0]), 32'd1);
        chk("rst_we_n", 32'(we_n[0]), 32'd1);
        chk("rst_dq_oe", 32'(dq_oe[0]), 32'd0);
        chk("rst_addr", 32'(sram_addr[0]), 32'd0);
        chk("rst_dq_o", dq_o[0], 32'd0);
        chk("rst_acks", 32'({m0_ack[0], m1_ack[0]}), 32'd0);
        chk("rst_rdata", m0_rdata[0], 32'd0);

        // Contention from reset: m0 reads 0x1, m1 writes 0x2, both held
        m0_we[0] = 1'b0; m0_addr[0] = 30'h1;
        m1_we[0] = 1'b1; m1_addr[0] = 30'h2; m1_wdata[0] = 32'hCAFEF00D;
        m0_req[0] = 1'b1; m1_req[0] = 1'b1;
        n = 0; both = 0;
        for (int c = 0; c < 80 && n < 4; c++) begin
            @(negedge clk);
            if (m0_ack[0] && m1_ack[0]) both = 1;
            if (m0_ack[0] || m1_ack[0]) begin
                ord[n] = int'(m1_ack[0]);
                n++;
            end
        end
        m0_req[0] = 1'b0; m1_req[0] = 1'b0;
        chk("cont_count", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) chk("cont_order", 32'(ord[i]), 32'(i % 2));
        chk("cont_both_ack", 32'(both), 32'd0);
        @(negedge clk);
        chk("cont_ack_width", 32'({m0_ack[0], m1_ack[0]}), 32'd0);
        chk("cont_rdata", m0_rdata[0], 32'h01010101);
        chk("cont_mem", mem[0][18'h00002], 32'hCAFEF00D);

        // Single read, write/read-back at top address, aliasing
        access(0, 1'b0, 1'b0, 30'h10, 32'h0, 3, 32'hDEADBEEF);
        access(0, 1'b1, 1'b1, 30'h3FFFF, 32'h12345678, 5, 32'h0);
        chk("wr_mem", mem[0][18'h3FFFF], 32'h12345678);
        chk("rdata_hold", m0_rdata[0], 32'hDEADBEEF);
        access(0, 1'b0, 1'b0, 30'h3FFFF, 32'h0, 3, 32'h12345678);
        access(0, 1'b0, 1'b1, 30'h0C0001, 32'hA5A5A5A5, 5, 32'h0);
        chk("alias_mem", mem[0][18'h00001], 32'hA5A5A5A5);

        // Wait-state sweep
        access(1, 1'b0, 1'b1, 30'h5, 32'h11112222, 7, 32'h0);
        access(1, 1'b1, 1'b0, 30'h5, 32'h0, 2, 32'h11112222);
        access(2, 1'b1, 1'b1, 30'h6, 32'h33334444, 4, 32'h0);
        access(2, 1'b0, 1'b0, 30'h6, 32'h0, 5, 32'h33334444);
        chk("sweep_mem1", mem[1][18'h5], 32'h11112222);
        chk("sweep_mem2", mem[2][18'h6], 32'h33334444);

        // Reset during the WE_ pulse of an m0 write (so rr_last points at m0)
        @(negedge clk);
        m0_we[0] = 1'b1; m0_addr[0] = 30'h7; m0_wdata[0] = 32'h77777777; m0_req[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!we_n[0]) begin
                seen = 1;
                break;
            end
        end
        chk("rst_wp_reached", 32'(seen), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_ce_n", 32'(ce_n[0]), 32'd1);
        chk("rst_async_we_n", 32'(we_n[0]), 32'd1);
        chk("rst_async_dq_oe", 32'(dq_oe[0]), 32'd0);
        m0_req[0] = 1'b0;
        ackseen = 0;
        repeat (2) begin
            @(negedge clk);
            if (m0_ack[0] || m1_ack[0]) ackseen = 1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m0_ack[0] || m1_ack[0]) ackseen = 1;
        end
        chk("rst_no_ack", 32'(ackseen), 32'd0);

        m0_we[0] = 1'b0; m0_addr[0] = 30'h10;
        m1_we[0] = 1'b0; m1_addr[0] = 30'h3FFFF;
        m0_req[0] = 1'b1; m1_req[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m0_ack[0] || m1_ack[0]) begin
                seen = 1;
                break;
            end
        end
        m0_req[0] = 1'b0; m1_req[0] = 1'b0;
        chk("post_rst_seen", 32'(seen), 32'd1);
        chk("post_rst_first", 32'({m0_ack[0], m1_ack[0]}), 32'b10);
        chk("post_rst_rdata", m0_rdata[0], 32'hDEADBEEF);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
